// File: rtl/p16_mod_stream_acc_if.sv
// Operand/result handshake bundle for the modulo (2^16 - 1) streaming accumulator.
// Both channels use valid/ready: a beat transfers on a rising edge where valid && ready.
interface p16_mod_stream_acc_if #(
    parameter int IDXW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_a;
    logic [15:0]     in_b;
    logic            in_acc;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_sum;
    logic            out_zero;
    logic            out_last;
    logic [IDXW-1:0] out_idx;

    modport master (
        output in_valid, in_a, in_b, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_zero, out_last, out_idx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_zero, out_last, out_idx
    );
endinterface

// File: rtl/p16_mod_stream_acc.sv
// Two-stage streaming end-around-carry adder with frame accumulator.
// S1 registers operands, S2 registers the normalised result; acc chains results within a frame.
module p16_mod_stream_acc #(
    parameter bit NORM = 1'b1,
    parameter int IDXW = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    p16_mod_stream_acc_if.slave   bus
);
    localparam logic [IDXW-1:0] IDX_ONE = {{(IDXW-1){1'b0}}, 1'b1};

    logic            r_s1_v;
    logic [15:0]     r_op_a;
    logic [15:0]     r_op_b;
    logic            r_s1_last;
    logic [IDXW-1:0] r_s1_idx;
    logic [IDXW-1:0] r_idx_cnt;
    logic [15:0]     r_acc;

    logic            r_out_valid;
    logic [15:0]     r_out_sum;
    logic            r_out_zero;
    logic            r_out_last;
    logic [IDXW-1:0] r_out_idx;

    logic [16:0]     w_raw;
    logic [15:0]     w_sum;
    logic [15:0]     w_norm;
    logic            w_is_zero;
    logic            w_s2_free;
    logic            w_s1_move;
    logic            w_in_ready;
    logic            w_accept;

    // End-around carry: the wrap-around add can never carry twice.
    assign w_raw     = {1'b0, r_op_a} + {1'b0, r_op_b};
    assign w_sum     = w_raw[15:0] + {15'd0, w_raw[16]};
    assign w_is_zero = (w_sum == 16'h0000) || (w_sum == 16'hFFFF);
    assign w_norm    = (NORM && (w_sum == 16'hFFFF)) ? 16'h0000 : w_sum;

    assign w_s2_free  = !r_out_valid || bus.out_ready;
    assign w_s1_move  = r_s1_v && w_s2_free;
    // An accumulate beat must wait until the beat ahead of it has updated acc.
    assign w_in_ready = (!r_s1_v || w_s1_move) && !(bus.in_acc && r_s1_v);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v      <= 1'b0;
            r_op_a      <= 16'h0000;
            r_op_b      <= 16'h0000;
            r_s1_last   <= 1'b0;
            r_s1_idx    <= '0;
            r_idx_cnt   <= '0;
            r_acc       <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_sum   <= 16'h0000;
            r_out_zero  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_v    <= 1'b1;
                r_op_a    <= bus.in_acc ? r_acc : bus.in_a;
                r_op_b    <= bus.in_b;
                r_s1_last <= bus.in_last;
                r_s1_idx  <= r_idx_cnt;
                r_idx_cnt <= bus.in_last ? '0 : (r_idx_cnt + IDX_ONE);
            end else if (w_s1_move) begin
                r_s1_v <= 1'b0;
            end

            if (w_s1_move) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_norm;
                r_out_zero  <= w_is_zero;
                r_out_last  <= r_s1_last;
                r_out_idx   <= r_s1_idx;
                r_acc       <= r_s1_last ? 16'h0000 : w_norm;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_zero  = r_out_zero;
    assign bus.out_last  = r_out_last;
    assign bus.out_idx   = r_out_idx;
endmodule

// File: doc/p16_mod_stream_acc.md
# p16_mod_stream_acc

Streaming, pipelined front/back end for the 16-bit end-around-carry node adder, which computes (a + b) mod (2^16 − 1). Accepts operand pairs over a valid/ready handshake and registers them into the combinational adder. It captures the adder result into an output register with its own handshake. An accumulator chains results across a frame, so a sequence of values is reduced modulo 2^16 − 1; the block sits between the operand source and the checksum/residue consumers.

## Interface
- NORM, 1, 1: result 0xFFFF (negative zero) is normalised to 0x0000 on output and in the accumulator; 0: passed through unchanged
- IDXW, 8, width of the in-frame beat index
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts the beat this cycle
- in_a  in  16  operand A; ignored when in_acc=1
- in_b  in  16  operand B
- in_acc  in  1  1: operand A is replaced by the accumulator
- in_last  in  1  last beat of frame; accumulator clears after this beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  16  modulo result
- out_zero  out  1  result ≡ 0 mod 2^16 − 1 (0x0000 or 0xFFFF before normalisation)
- out_last  out  1  copy of in_last for this beat
- out_idx  out  IDXW  beat index within the frame, 0 for the first beat

## Operation
- **Stage S1 (operand register):** holds s1_v, opA, opB, last and idx, and drives the adder. opA is acc when in_acc=1, else in_a.
- **Stage S2 (output register):** holds out_valid, out_sum, out_zero, out_last and out_idx.
- **Transfers:**
  - s2_free = !out_valid || out_ready.
  - s1_move = s1_v && s2_free.
  - The beat is accepted when in_valid && in_ready.
- **in_ready:** in_ready = (!s1_v || s1_move) && !(in_acc && s1_v).
  - The second term is the accumulate hazard stall: the accumulator is not updated until S1 moves.
  - in_ready may depend on in_acc. The source must hold in_acc stable while in_valid is high.
- **On s1_move:**
  - out_sum ← norm(sum) and out_zero ← (sum==0x0000 || sum==0xFFFF).
  - out_last and out_idx are copied from S1.
  - acc ← last ? 0 : norm(sum).
- **Normalisation:** norm(x) = (NORM && x==0xFFFF) ? 0x0000 : x.
- **Frame index counter:**
  - Counts accepted beats; the value is stored in S1 with the beat.
  - It resets to 0 after an accepted in_last beat.
  - It wraps from 2^IDXW − 1 to 0 without a flag.
- **Holding:** when S2 is full and out_ready=0, S2 holds, S1 holds, and in_ready=0 if S1 is occupied. No beat is dropped or duplicated.
- **Simultaneous S1 move and new accept:** S1 is reloaded in the same cycle, giving full throughput.
- **Frame start:** in_acc=1 on the first beat of a frame uses acc=0.
- **Reset mid-frame:** all state clears. Partial frames and in-flight beats are discarded; no output is produced for them.

## Timing
- **Reset values:** out_valid=0, out_sum=0, out_zero=0, out_last=0, out_idx=0, s1_v=0, acc=0, frame counter=0. The cycle after reset, in_ready=1.
- **Latency:** a beat accepted at edge k appears with out_valid=1 after edge k+1 (2-cycle latency), provided S2 is free.
- **Throughput:**
  - in_acc=0 beats: 1 per cycle under continuous out_ready=1.
  - Back-to-back in_acc=1 beats: 1 per 2 cycles, because of the hazard stall.
- **Output stability:** out_* stays stable while out_valid=1 && out_ready=0.
- **Critical path:** one pass through the adder plus normalisation, from S1 to S2/acc. No adder-to-adder combinational chaining.

## Test plan
- **Basic add:** in_acc=0, (0x1234,0x0001), then (0xFFFF,0x0001), then (0x8000,0x8000).
  - Results on consecutive cycles, starting 2 cycles after the first accept: 0x1235, 0x0001 (end-around carry), 0x0001.
  - in_ready stays at 1 throughout.
- **Negative zero:** (0x0000,0xFFFF).
  - NORM=1: out_sum=0x0000, out_zero=1.
  - NORM=0: out_sum=0xFFFF, out_zero=1.
  - (0x0001,0xFFFE) gives the same result.
- **Accumulate frame:** b = 0x7FFF, 0x8000, 0x0002, with in_acc=1 and in_last on the third beat.
  - Outputs: 0x7FFF, 0x0000 (NORM=1), 0x0002.
  - out_idx = 0, 1, 2; out_last = 0, 0, 1.
  - in_ready drops for one cycle between beats.
  - The next frame starts from acc=0 with idx=0.
- **Backpressure:** out_ready=0 for 5 cycles while streaming in_acc=0 beats.
  - Exactly 2 beats are accepted, then in_ready=0.
  - out_sum is held.
  - After out_ready=1, all beats emerge in order with no loss or duplication.
- **Reset mid-operation:** assert rst_n=0 with S1 and S2 full and acc=0x1234.
  - The next cycle: out_valid=0 and in_ready=1.
  - A following in_acc=1 beat with b=0x0005 outputs 0x0005 with idx=0.
- **Index wrap:** with IDXW=2, send 5 beats with no in_last.
  - out_idx = 0, 1, 2, 3, 0.
